// File: rtl/imem_dump_reader.sv
// imem_dump_reader
//   Read-side engine for the IF instruction memory. Walks the inclusive word
//   range start_addr..end_addr (wrapping modulo 2^ADDR_W) over the memory's
//   synchronous read port and streams each word out on a valid/ready port.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start, abort          begin a dump (IDLE only) / cancel and flush a dump
//   start_addr, end_addr  inclusive range, sampled when start is accepted
//   busy, done            dump in progress / 1-cycle completion pulse
//   mem_rd_en/addr/data   synchronous read port (data valid 1 cycle after en)
//   out_valid/ready       output handshake
//   out_data/addr/last    word, its address, and end-of-range flag
module imem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   reads_left;
    logic              infl_vld;
    logic              infl_last;
    logic [ADDR_W-1:0] infl_addr;

    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] buf_addr [2];
    logic              buf_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              accept_start;
    logic              flush;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [1:0]        committed;

    assign accept_start = (state == S_IDLE) && start && !abort;
    assign flush        = abort && ((state == S_READ) || (state == S_DRAIN));
    assign pop          = out_valid && out_ready;

    // Words still owned by the block after this cycle's handshake. Counting
    // the pop here lets a new read go out in the same cycle a word leaves,
    // which is what sustains one word per cycle with out_ready held high.
    assign committed  = count + {1'b0, infl_vld} - {1'b0, pop};
    assign issue      = (state == S_READ) && !abort && (reads_left != '0) && (committed < 2'd2);
    assign last_issue = issue && (reads_left == (ADDR_W+1)'(1));

    assign busy        = (state == S_READ) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_addr;
    assign out_valid   = (count != 2'd0);
    assign out_data    = buf_data[rd_ptr];
    assign out_addr    = buf_addr[rd_ptr];
    assign out_last    = buf_last[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_start) state_nxt = S_READ;
            end
            S_READ: begin
                if (abort)           state_nxt = S_IDLE;
                else if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave on the cycle the final word is handed over.
                if (abort)
                    state_nxt = S_IDLE;
                else if (!infl_vld && ((count == 2'd0) || ((count == 2'd1) && pop)))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_addr     <= '0;
            reads_left  <= '0;
            infl_vld    <= 1'b0;
            infl_last   <= 1'b0;
            infl_addr   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_addr[0] <= '0;
            buf_addr[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else if (flush) begin
            // Drop buffered words and any read still in flight.
            reads_left <= '0;
            infl_vld   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
        end else begin
            if (accept_start) begin
                rd_addr    <= start_addr;
                // Modular difference gives the wrapped length minus one.
                reads_left <= {1'b0, end_addr - start_addr} + (ADDR_W+1)'(1);
            end else if (issue) begin
                rd_addr    <= rd_addr + ADDR_W'(1);
                reads_left <= reads_left - (ADDR_W+1)'(1);
            end

            infl_vld <= issue;
            if (issue) begin
                infl_addr <= rd_addr;
                infl_last <= last_issue;
            end

            if (infl_vld) begin
                buf_data[wr_ptr] <= mem_rd_data;
                buf_addr[wr_ptr] <= infl_addr;
                buf_last[wr_ptr] <= infl_last;
                wr_ptr           <= ~wr_ptr;
            end

            if (pop) rd_ptr <= ~rd_ptr;

            count <= count + {1'b0, infl_vld} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_imem_dump_reader.sv
// tb_imem_dump_reader
//   Scoreboard bench for imem_dump_reader. Each dump pushes the expected word
//   sequence (address walk over the preloaded memory array) into a queue; a
//   monitor on the opposite clock edge pops and compares every handshake.
module tb_imem_dump_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    always #5 clock = ~clock;

    imem_dump_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } word_t;

    logic [DATA_W-1:0] mem [DEPTH];
    word_t             exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_count = 0;
    int hs_count = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc = 0;
    int occ = 0;
    logic [ADDR_W-1:0] dump_start = '0;
    logic [ADDR_W-1:0] exp_rd_a;
    bit    last_hs_prev = 1'b0;
    bit    hold_pending = 1'b0;
    word_t hold_word;
    word_t exp_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read instruction memory; also checks the read address walk.
    always @(posedge clock) begin
        cyc++;
        if (mem_rd_en === 1'b1) begin
            exp_rd_a = dump_start + ADDR_W'(rd_count);
            chk("rd_addr", 64'(mem_rd_addr), 64'(exp_rd_a));
            mem_rd_data <= mem[mem_rd_addr];
            rd_count++;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            hold_pending = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (hold_pending)
                chk("stable", 64'({out_valid, out_data, out_addr, out_last}), 64'({1'b1, hold_word}));
            hold_pending = 1'b0;

            chk("done", 64'(done), 64'(last_hs_prev));
            last_hs_prev = 1'b0;

            if (busy === 1'b1) begin
                occ = rd_count - hs_count + int'(mem_rd_en) - int'(out_valid && out_ready);
                chk("occupancy_le_2", 64'(occ > 2), 64'(0));
            end

            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got addr %h data %h, expected none", out_addr, out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", 64'({out_data, out_addr, out_last}), 64'(exp_w));
                    last_hs_prev = exp_w.last;
                end
                if (hs_count == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_count++;
            end else if (out_valid === 1'b1 && abort !== 1'b1) begin
                hold_pending = 1'b1;
                hold_word    = {out_data, out_addr, out_last};
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: the words from s up to e inclusive, walking upward and
    // wrapping past the top of memory.
    task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, output int n);
        logic [ADDR_W-1:0] a;
        word_t w;
        a = s;
        n = 1;
        while (a != e) begin
            a = a + 1'b1;
            n++;
        end
        a = s;
        for (int k = 0; k < n; k++) begin
            w.data = mem[a];
            w.addr = a;
            w.last = (k == n - 1);
            exp_q.push_back(w);
            a = a + 1'b1;
        end
        rd_count   = 0;
        hs_count   = 0;
        dump_start = s;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit rand_ready, output int busy_cycles);
        int guard;
        guard = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && guard < 300) begin
            if (busy === 1'b1) busy_cycles++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            guard++;
        end
        chk("done_reached", 64'(done), 64'(1));
    endtask

    task automatic finish_dump(input int n);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("reads_issued", 64'(rd_count), 64'(n));
        chk("busy_in_done", 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      64'(busy),        64'(0));
        chk({tag, "_done"},      64'(done),        64'(0));
        chk({tag, "_rd_en"},     64'(mem_rd_en),   64'(0));
        chk({tag, "_rd_addr"},   64'(mem_rd_addr), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid),   64'(0));
        chk({tag, "_out_data"},  64'(out_data),    64'(0));
        chk({tag, "_out_addr"},  64'(out_addr),    64'(0));
        chk({tag, "_out_last"},  64'(out_last),    64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bc;
        int guard;
        logic [ADDR_W-1:0] s;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[1] = 32'hFFFF_FFFF;
        mem[2] = 32'hABCB_FFFF;
        mem[4] = 32'h1234_5678;
        mem[5] = 32'h1234_5677;
        mem[6] = 32'h1111_1111;

        // Reset state
        #2;
        check_all_zero("reset");
        step();
        reset = 1'b1;
        step();

        // 1: 1..6 with out_ready=1, back-to-back
        out_ready = 1'b1;
        launch(10'd1, 10'd6, n);
        run_until_done(1'b0, bc);
        finish_dump(n);
        chk("back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'(5));
        step();
        chk("done_one_pulse", 64'(done), 64'(0));

        // 2: single word, busy for 3 cycles; start in DONE is ignored
        launch(10'd5, 10'd5, n);
        run_until_done(1'b0, bc);
        finish_dump(n);
        chk("busy_cycles_n1", 64'(bc), 64'(3));
        start_addr = 10'd10;
        end_addr   = 10'd12;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'(0));
        step();
        chk("start_in_done_no_read", 64'(mem_rd_en), 64'(0));

        // 3: wrap 1022..1
        launch(10'd1022, 10'd1, n);
        chk("wrap_len", 64'(n), 64'(4));
        run_until_done(1'b0, bc);
        finish_dump(n);
        step();

        // 4: random out_ready, with a start pulse while busy
        launch(10'd1, 10'd6, n);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (k == 1) begin
                start_addr = 10'd100;
                end_addr   = 10'd200;
                start      = 1'b1;
            end
            step();
            start = 1'b0;
        end
        run_until_done(1'b1, bc);
        finish_dump(n);
        step();

        // start together with abort in IDLE: abort wins
        start_addr = 10'd0;
        end_addr   = 10'd3;
        start      = 1'b1;
        abort      = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(0));
        step();
        chk("start_abort_no_read", 64'(mem_rd_en), 64'(0));

        // 5: abort after the 3rd accepted word, then a clean 2..4 dump
        launch(10'd1, 10'd6, n);
        guard = 0;
        while (hs_count < 3 && guard < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        chk("abort_reach_3", 64'(hs_count), 64'(3));
        out_ready = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        exp_q.delete();
        repeat (4) step();
        chk("abort_no_done", 64'(done), 64'(0));
        out_ready = 1'b1;
        launch(10'd2, 10'd4, n);
        run_until_done(1'b0, bc);
        finish_dump(n);
        step();

        // 6: async reset while words are buffered
        out_ready = 1'b0;
        launch(10'd1, 10'd6, n);
        repeat (5) step();
        chk("buffered_before_reset", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_idle", 64'(busy), 64'(0));
        out_ready = 1'b1;
        launch(10'd4, 10'd6, n);
        run_until_done(1'b0, bc);
        finish_dump(n);
        step();

        // Random ranges (including wrap) with random back-pressure
        for (int r = 0; r < 8; r++) begin
            int len;
            s   = ADDR_W'($urandom_range(0, DEPTH - 1));
            len = $urandom_range(1, 8);
            launch(s, s + ADDR_W'(len - 1), n);
            chk("rand_len", 64'(n), 64'(len));
            run_until_done(1'b1, bc);
            finish_dump(n);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
